// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and configuration widths for the pattern sequencer.
package seq_pkg;
    localparam int SEQ_LEN_W = 10;
    localparam int DIV_W = 5;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/seq_prescaler.sv
// seq_prescaler: tick divider counting 0..div; held at 0 while disabled so a run ticks at once.
module seq_prescaler
    import seq_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         aclr_n,
    input  logic         en,
    input  logic [W-1:0] div,
    output logic         tick
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) cnt <= '0;
        else cnt <= (!en || cnt == div) ? '0 : cnt + W'(1);
    end

    assign tick = en && cnt == '0;
endmodule

// File: rtl/seq_pattern_player.sv
// seq_pattern_player: steps a read address through pattern RAM once per divided tick,
// registering each returned word onto pat_out.
module seq_pattern_player
    import seq_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = SEQ_LEN_W
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic [AW-1:0]    seq_length,
    input  logic [DIV_W-1:0] div_base,
    input  logic             loop_mode,
    input  logic             start,
    input  logic             stop,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd,
    input  logic [DW-1:0]    mem_q,
    output logic [DW-1:0]    pat_out,
    output logic             pat_valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       loop_cnt
);
    state_t state, state_n;
    logic [AW-1:0] addr, len_q;
    logic [DIV_W-1:0] div_q;
    logic loop_q, tick, last, load;

    seq_prescaler #(.W(DIV_W)) u_pre (
        .clk(clk),
        .aclr_n(aclr_n),
        .en(state == RUN),
        .div(div_q),
        .tick(tick)
    );

    assign last = addr == len_q - AW'(1);
    assign mem_addr = addr;
    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        load = 1'b0;
        mem_rd = 1'b0;
        case (state)
            IDLE: begin
                load = start && !stop && seq_length != '0;
                state_n = load ? RUN : IDLE;
            end
            RUN: begin
                mem_rd = tick;
                state_n = (stop || (tick && last && !loop_q)) ? DRAIN : RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    // The address advances on every read, including one coinciding with stop,
    // so a pass finished on the abort cycle is still counted.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            addr <= '0;
            len_q <= '0;
            div_q <= '0;
            loop_q <= 1'b0;
            loop_cnt <= '0;
            pat_out <= '0;
            pat_valid <= 1'b0;
            done <= 1'b0;
        end else begin
            pat_valid <= mem_rd;
            done <= state == DRAIN;
            if (mem_rd) pat_out <= mem_q;
            if (load) begin
                len_q <= seq_length;
                div_q <= div_base;
                loop_q <= loop_mode;
                addr <= '0;
                loop_cnt <= '0;
            end else if (mem_rd) begin
                if (!last) addr <= addr + AW'(1);
                else if (loop_q) begin
                    addr <= '0;
                    if (loop_cnt != 8'hFF) loop_cnt <= loop_cnt + 8'd1;
                end
            end
        end
    end
endmodule
